// File: rtl/definitions_pkg.sv
// Shared definitions for the image link controller: frame marker bytes,
// command/status bit positions and the link FSM state type.
// Optional build macro: IMG_LINK_CKSUM_EN adds the checksum trailer state.
package definitions_pkg;

   // Frame marker bytes
   localparam logic [7:0] IMG_HDR = 8'hA5;
   localparam logic [7:0] IMG_EOF = 8'h5A;

   // Command byte fields; bits [7:4] are reserved and ignored
   localparam int CMD_KERNEL_BIT = 0;
   localparam int CMD_FILL_LSB   = 1;
   localparam int CMD_FILL_MSB   = 2;
   localparam int CMD_BYPASS_BIT = 3;

   // Status byte bit positions; the upper nibble is always zero
   localparam int STAT_ONE_BIT  = 0;
   localparam int STAT_OVF_BIT  = 1;
   localparam int STAT_XTRA_BIT = 2;
   localparam int STAT_TO_BIT   = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_STREAM,
      ST_FLUSH,
      ST_TRAIL,
      ST_STAT
`ifdef IMG_LINK_CKSUM_EN
      ,
      ST_CKS
`endif
   } link_state_t;

   // Assemble the status byte from the sticky frame flags
   function automatic logic [7:0] status_byte(input logic to_flag,
                                              input logic xtra_flag,
                                              input logic ovf_flag);
      logic [7:0] s;
      s                = '0;
      s[STAT_ONE_BIT]  = 1'b1;
      s[STAT_OVF_BIT]  = ovf_flag;
      s[STAT_XTRA_BIT] = xtra_flag;
      s[STAT_TO_BIT]   = to_flag;
      return s;
   endfunction

endpackage

// File: rtl/img_link_fifo.sv
// Synchronous first-word-fall-through FIFO buffering processed pixels on
// their way to the UART TX side. DEPTH must be a power of two.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module img_link_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             clear,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr[AW-1:0]];

   // Storage write
   // NOTE: the data array has no reset; occupancy is defined by the pointers alone.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= wdata;
      end
   end

   // Pointer update, with a synchronous clear that discards all contents
   // NOTE: sequential state is always assigned with non-blocking <= so every
   // register samples values from before the clock edge.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/image_link_ctrl.sv
// Frame-level controller between the UART byte stream and the edge core.
// Parses HDR/CMD, streams IMG_W*IMG_H pixels to the core (or a bypass path
// straight into the output FIFO), drains the FIFO to UART TX under
// back-pressure and closes the frame with EOF and a status byte.
// Optional build macro: IMG_LINK_CKSUM_EN appends an XOR checksum of all
// transmitted pixels after the status byte.
module image_link_ctrl #(
   parameter int PIX_W       = 8,
   parameter int IMG_W       = 64,
   parameter int IMG_H       = 64,
   parameter int OBUF_DEPTH  = 16,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic [PIX_W-1:0] rx_data,
   input  logic             rx_valid,
   output logic [PIX_W-1:0] core_pix,
   output logic             core_pix_valid,
   output logic             kernel_select,
   output logic [1:0]       fill_select,
   input  logic [PIX_W-1:0] core_out,
   input  logic             core_out_valid,
   output logic [PIX_W-1:0] tx_data,
   output logic             tx_wr,
   input  logic             tx_full,
   output logic             busy
);

   import definitions_pkg::*;

   localparam int N      = IMG_W * IMG_H;
   localparam int CNT_W  = $clog2(N + 1);
   localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

   link_state_t       state;
   logic [CNT_W-1:0]  in_cnt;
   logic [CNT_W-1:0]  out_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic              bypass;
   logic              to_flag;
   logic              xtra_flag;
   logic              ovf_flag;
`ifdef IMG_LINK_CKSUM_EN
   logic [PIX_W-1:0]  cksum;
`endif

   logic             accept_st;
   logic             src_valid;
   logic [PIX_W-1:0] src_data;
   logic             out_req;
   logic             room;
   logic             flush_done;
   logic             timeout_hit;
   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_clear;
   logic [PIX_W-1:0] fifo_rdata;
   logic             fifo_full;
   logic             fifo_empty;

   // Output pixels are taken from the core, or from RX directly in bypass,
   // only while the frame body is in flight; surplus ones just raise XTRA.
   assign accept_st   = (state == ST_STREAM) || (state == ST_FLUSH);
   assign src_valid   = bypass ? ((state == ST_STREAM) && rx_valid) : core_out_valid;
   assign src_data    = bypass ? rx_data : core_out;
   assign out_req     = accept_st && src_valid;
   assign room        = (out_cnt < CNT_W'(N));
   assign fifo_pop    = accept_st && !fifo_empty && !tx_full;
   assign fifo_push   = out_req && room && (!fifo_full || fifo_pop);
   assign flush_done  = (state == ST_FLUSH) && (out_cnt == CNT_W'(N)) && fifo_empty;
   assign timeout_hit = (state == ST_FLUSH) && !flush_done
                        && (idle_cnt == IDLE_W'(TIMEOUT_CYC));
   assign fifo_clear  = ((state == ST_CMD) && rx_valid) || timeout_hit;

   img_link_fifo #(
      .WIDTH (PIX_W),
      .DEPTH (OBUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rstN  (rstN),
      .clear (fifo_clear),
      .push  (fifo_push),
      .wdata (src_data),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Link FSM with all outputs, counters and sticky flags registered
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state          <= ST_IDLE;
         in_cnt         <= '0;
         out_cnt        <= '0;
         idle_cnt       <= '0;
         bypass         <= 1'b0;
         to_flag        <= 1'b0;
         xtra_flag      <= 1'b0;
         ovf_flag       <= 1'b0;
         core_pix       <= '0;
         core_pix_valid <= 1'b0;
         kernel_select  <= 1'b0;
         fill_select    <= '0;
         tx_data        <= '0;
         tx_wr          <= 1'b0;
         busy           <= 1'b0;
`ifdef IMG_LINK_CKSUM_EN
         cksum          <= '0;
`endif
      end else begin
         core_pix_valid <= 1'b0;
         tx_wr          <= 1'b0;

         // FIFO drain to TX; only possible in STREAM/FLUSH
         if (fifo_pop) begin
            tx_wr   <= 1'b1;
            tx_data <= fifo_rdata;
`ifdef IMG_LINK_CKSUM_EN
            cksum   <= cksum ^ fifo_rdata;
`endif
         end

         // An accepted output pixel counts even when the full FIFO drops it
         if (out_req) begin
            if (room) begin
               out_cnt <= out_cnt + CNT_W'(1);
               if (fifo_full && !fifo_pop) ovf_flag <= 1'b1;
            end else begin
               xtra_flag <= 1'b1;
            end
         end

         case (state)
            ST_IDLE: begin
               if (rx_valid && (rx_data == PIX_W'(IMG_HDR))) begin
                  state <= ST_CMD;
                  busy  <= 1'b1;
               end
            end

            ST_CMD: begin
               if (rx_valid) begin
                  kernel_select <= rx_data[CMD_KERNEL_BIT];
                  fill_select   <= rx_data[CMD_FILL_MSB:CMD_FILL_LSB];
                  bypass        <= rx_data[CMD_BYPASS_BIT];
                  in_cnt        <= '0;
                  out_cnt       <= '0;
                  idle_cnt      <= '0;
                  to_flag       <= 1'b0;
                  xtra_flag     <= 1'b0;
                  ovf_flag      <= 1'b0;
`ifdef IMG_LINK_CKSUM_EN
                  cksum         <= '0;
`endif
                  state         <= ST_STREAM;
               end
            end

            ST_STREAM: begin
               if (rx_valid) begin
                  if (!bypass) begin
                     core_pix       <= rx_data;
                     core_pix_valid <= 1'b1;
                  end
                  in_cnt <= in_cnt + CNT_W'(1);
                  if (in_cnt == CNT_W'(N - 1)) state <= ST_FLUSH;
               end
            end

            ST_FLUSH: begin
               if (src_valid) begin
                  idle_cnt <= '0;
               end else if (idle_cnt != IDLE_W'(TIMEOUT_CYC)) begin
                  idle_cnt <= idle_cnt + IDLE_W'(1);
               end
               if (flush_done) begin
                  state <= ST_TRAIL;
               end else if (timeout_hit) begin
                  to_flag <= 1'b1;
                  state   <= ST_TRAIL;
               end
            end

            ST_TRAIL: begin
               if (!tx_full) begin
                  tx_wr   <= 1'b1;
                  tx_data <= PIX_W'(IMG_EOF);
                  state   <= ST_STAT;
               end
            end

            ST_STAT: begin
               if (!tx_full) begin
                  tx_wr   <= 1'b1;
                  tx_data <= PIX_W'(status_byte(to_flag, xtra_flag, ovf_flag));
`ifdef IMG_LINK_CKSUM_EN
                  state   <= ST_CKS;
`else
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
`endif
               end
            end

`ifdef IMG_LINK_CKSUM_EN
            ST_CKS: begin
               if (!tx_full) begin
                  tx_wr   <= 1'b1;
                  tx_data <= cksum;
                  state   <= ST_IDLE;
                  busy    <= 1'b0;
               end
            end
`endif

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
